// File: rtl/riscv_rf_wb_arbiter.sv
// Write-back scheduler for the two RF write ports. LSU owns port B, and ALU/debug share port A.
// It also tracks outstanding load destinations in a per-register busy scoreboard.
module riscv_rf_wb_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8,
  localparam int NUM_WORDS   = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
  input  logic [DATA_WIDTH-1:0] alu_wdata_i,
  output logic                  alu_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_ready_o,
  input  logic                  dbg_valid_i,
  input  logic [ADDR_WIDTH-1:0] dbg_waddr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
  output logic                  dbg_ready_o,
  input  logic                  rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0] rsv_addr_i,
  output logic [NUM_WORDS-1:0]  busy_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] X0 = '0;
  localparam logic [NUM_WORDS-1:0] ONE = NUM_WORDS'(1);

  logic [7:0]           starve_cnt;
  logic                 dbg_prio;
  logic                 alu_conflict;
  logic                 dbg_conflict;
  logic                 alu_fire;
  logic                 dbg_fire;
  logic                 lsu_fire;
  logic [NUM_WORDS-1:0] busy_set;
  logic [NUM_WORDS-1:0] busy_clr;

  // Debug only takes precedence once it has waited the full starvation window.
  assign dbg_prio     = dbg_valid_i && (starve_cnt == LIMIT);
  assign alu_conflict = lsu_valid_i && (alu_waddr_i != X0) && (alu_waddr_i == lsu_waddr_i);
  assign dbg_conflict = lsu_valid_i && (dbg_waddr_i != X0) && (dbg_waddr_i == lsu_waddr_i);

  assign lsu_ready_o = !rst;
  assign alu_ready_o = !rst && !dbg_prio && !alu_conflict;
  assign dbg_ready_o = !rst && (dbg_prio || !alu_valid_i) && !dbg_conflict;

  assign alu_fire = alu_valid_i && alu_ready_o;
  assign dbg_fire = dbg_valid_i && dbg_ready_o;
  assign lsu_fire = lsu_valid_i && lsu_ready_o;

  assign busy_set = (rsv_valid_i && rsv_addr_i != X0) ? (ONE << rsv_addr_i) : '0;
  assign busy_clr = lsu_fire ? (ONE << lsu_waddr_i) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!dbg_valid_i || dbg_fire) begin
      starve_cnt <= '0;
    end else if (alu_valid_i && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      we_b_o    <= 1'b0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
      busy_o    <= '0;
    end else begin
      we_a_o <= 1'b0;
      if (dbg_fire) begin
        we_a_o    <= (dbg_waddr_i != X0);
        waddr_a_o <= dbg_waddr_i;
        wdata_a_o <= dbg_wdata_i;
      end else if (alu_fire) begin
        we_a_o    <= (alu_waddr_i != X0);
        waddr_a_o <= alu_waddr_i;
        wdata_a_o <= alu_wdata_i;
      end
      we_b_o <= lsu_fire && (lsu_waddr_i != X0);
      if (lsu_fire) begin
        waddr_b_o <= lsu_waddr_i;
        wdata_b_o <= lsu_wdata_i;
      end
      // A same-cycle set overrides the clear, because a new load is now outstanding.
      busy_o <= ((busy_o & ~busy_clr) | busy_set) & ~ONE;
    end
  end

endmodule
